// File: rtl/rgb_frame_streamer_pkg.sv
// Shared constants and types for the RGB frame readout path.
// The RGB frame layout constants are also used by the colour-space write stage.
package rgb_frame_streamer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [17:0] C_RGB_BASE     = 18'd146944;
    localparam int unsigned C_FRAME_PIXELS = 76800;
    localparam int unsigned C_READ_LATENCY = 3;
    localparam int unsigned C_FIFO_DEPTH   = 8;

    // Three 16-bit words carry two pixels, MSB byte first: {R0,G0},{B0,R1},{G1,B1}.
    function automatic logic [23:0] group_pixel(input logic [47:0] grp, input logic phase);
        return phase ? grp[23:0] : grp[47:24];
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous single-clock word FIFO with occupancy count.
// Caller guarantees no push when full and no pop when empty.
module sync_word_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         CLOCK_50_I,
    input  logic                         Resetn,
    input  logic                         i_clear,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/rgb_frame_streamer.sv
// Streams the packed RGB frame out of SRAM as one pixel per valid/ready handshake,
// prefetching through a credit-limited FIFO to hide SRAM read latency.
module rgb_frame_streamer
    import rgb_frame_streamer_pkg::*;
#(
    parameter logic [17:0] RGB_BASE     = C_RGB_BASE,
    parameter int unsigned FRAME_PIXELS = C_FRAME_PIXELS,
    parameter int unsigned READ_LATENCY = C_READ_LATENCY,
    parameter int unsigned FIFO_DEPTH   = C_FIFO_DEPTH
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] address,
    output logic        write_en_n,
    input  logic        pixel_ready,
    output logic        pixel_valid,
    output logic [7:0]  pixel_R,
    output logic [7:0]  pixel_G,
    output logic [7:0]  pixel_B,
    output logic        busy,
    output logic        frame_done
);
    localparam int unsigned FRAME_WORDS = FRAME_PIXELS * 3 / 2;
    localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);

    state_t              r_state, w_state_next;
    logic [16:0]         r_words_issued, r_pixels_sent;
    logic [CW-1:0]       r_in_flight;
    logic [READ_LATENCY:0] r_pipe;
    logic [17:0]         r_address;
    logic [1:0]          r_asm_cnt;
    logic [15:0]         r_asm0, r_asm1;
    logic [47:0]         r_shd;
    logic                r_shd_vld;
    logic [23:0]         r_pend, r_pixel;
    logic                r_pend_vld, r_pix_valid;

    logic                w_clear, w_credit, w_issue, w_push, w_pop;
    logic                w_xfer, w_load, w_shd_take, w_last;
    logic [15:0]         w_fifo_dout;
    logic [CW-1:0]       w_fifo_count;
    logic                w_fifo_empty;

    assign w_clear    = (r_state != S_STREAM);
    assign w_credit   = ({1'b0, w_fifo_count} + {1'b0, r_in_flight}) < (CW+1)'(FIFO_DEPTH);
    assign w_issue    = (r_state == S_STREAM) && (r_words_issued < 17'(FRAME_WORDS)) && w_credit;
    assign w_push     = r_pipe[READ_LATENCY];
    assign w_xfer     = r_pix_valid && pixel_ready;
    assign w_load     = !r_pix_valid || w_xfer;
    assign w_shd_take = w_load && !r_pend_vld && r_shd_vld;
    // A third word may be popped while the shadow group is handed to the output this cycle.
    assign w_pop      = (r_state == S_STREAM) && !w_fifo_empty &&
                        ((r_asm_cnt != 2'd2) || !r_shd_vld || w_shd_take);
    assign w_last     = w_xfer && (r_pixels_sent == 17'(FRAME_PIXELS - 1));

    sync_word_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50_I (CLOCK_50_I),
        .Resetn     (Resetn),
        .i_clear    (w_clear),
        .i_push     (w_push),
        .i_din      (SRAM_read_data),
        .i_pop      (w_pop),
        .o_dout     (w_fifo_dout),
        .o_count    (w_fifo_count),
        .o_empty    (w_fifo_empty)
    );

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        frame_done   = 1'b0;
        unique case (r_state)
            S_IDLE:   if (start) w_state_next = S_STREAM;
            S_STREAM: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                busy         = 1'b1;
                frame_done   = 1'b1;
                w_state_next = S_IDLE;
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_address      <= RGB_BASE;
            r_words_issued <= '0;
            r_pixels_sent  <= '0;
            r_in_flight    <= '0;
            r_pipe         <= '0;
        end else if (w_clear) begin
            r_address      <= RGB_BASE;
            r_words_issued <= '0;
            r_pixels_sent  <= '0;
            r_in_flight    <= '0;
            r_pipe         <= '0;
        end else begin
            if (w_issue) begin
                r_address      <= RGB_BASE + 18'(r_words_issued);
                r_words_issued <= r_words_issued + 17'd1;
            end
            if (w_xfer) r_pixels_sent <= r_pixels_sent + 17'd1;
            r_in_flight <= r_in_flight + CW'(w_issue) - CW'(w_push);
            r_pipe      <= {r_pipe[READ_LATENCY-1:0], w_issue};
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_asm_cnt   <= '0;
            r_asm0      <= '0;
            r_asm1      <= '0;
            r_shd       <= '0;
            r_shd_vld   <= 1'b0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_pixel     <= '0;
            r_pix_valid <= 1'b0;
        end else if (w_clear) begin
            r_asm_cnt   <= '0;
            r_shd_vld   <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pixel     <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                case (r_asm_cnt)
                    2'd0:    begin r_asm0 <= w_fifo_dout; r_asm_cnt <= 2'd1; end
                    2'd1:    begin r_asm1 <= w_fifo_dout; r_asm_cnt <= 2'd2; end
                    default: r_asm_cnt <= 2'd0;
                endcase
            end
            if (w_pop && (r_asm_cnt == 2'd2)) begin
                r_shd     <= {r_asm0, r_asm1, w_fifo_dout};
                r_shd_vld <= 1'b1;
            end else if (w_shd_take) begin
                r_shd_vld <= 1'b0;
            end
            if (w_load) begin
                if (r_pend_vld) begin
                    r_pixel     <= r_pend;
                    r_pix_valid <= 1'b1;
                    r_pend_vld  <= 1'b0;
                end else if (r_shd_vld) begin
                    r_pixel     <= group_pixel(r_shd, 1'b0);
                    r_pend      <= group_pixel(r_shd, 1'b1);
                    r_pend_vld  <= 1'b1;
                    r_pix_valid <= 1'b1;
                end else begin
                    r_pix_valid <= 1'b0;
                end
            end
        end
    end

    assign address     = r_address;
    assign write_en_n  = 1'b1;
    assign pixel_valid = r_pix_valid;
    assign pixel_R     = r_pixel[23:16];
    assign pixel_G     = r_pixel[15:8];
    assign pixel_B     = r_pixel[7:0];

endmodule

// File: tb/tb_rgb_frame_streamer.sv
// Bench for rgb_frame_streamer: SRAM model with 3-clock read latency, byte-stream
// reference model, and directed reset / stall / restart / full-frame scenarios.
module tb_rgb_frame_streamer;
    // Small frame placed so its last word lands on the top of the 18-bit address space.
    localparam logic [17:0] TB_BASE   = 18'h3FA00;
    localparam int unsigned TB_PIXELS = 1024;
    localparam logic [17:0] TB_LAST   = 18'h3FFFF;

    logic        CLOCK_50_I = 1'b0;
    logic        Resetn;
    logic        start;
    logic [15:0] SRAM_read_data;
    logic [17:0] address;
    logic        write_en_n;
    logic        pixel_ready;
    logic        pixel_valid;
    logic [7:0]  pixel_R, pixel_G, pixel_B;
    logic        busy;
    logic        frame_done;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [15:0] mem [0:262143];
    logic [15:0] r_d1, r_d2, r_d3;

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    rgb_frame_streamer #(
        .RGB_BASE     (TB_BASE),
        .FRAME_PIXELS (TB_PIXELS)
    ) dut (
        .CLOCK_50_I     (CLOCK_50_I),
        .Resetn         (Resetn),
        .start          (start),
        .SRAM_read_data (SRAM_read_data),
        .address        (address),
        .write_en_n     (write_en_n),
        .pixel_ready    (pixel_ready),
        .pixel_valid    (pixel_valid),
        .pixel_R        (pixel_R),
        .pixel_G        (pixel_G),
        .pixel_B        (pixel_B),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    // Address sampled at an edge appears on the data bus three edges later.
    always @(posedge CLOCK_50_I) begin
        r_d1 <= mem[address];
        r_d2 <= r_d1;
        r_d3 <= r_d2;
    end
    assign SRAM_read_data = r_d3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The frame is a flat byte stream R,G,B,R,G,B,... packed two bytes per word, high byte first.
    function automatic logic [7:0] frame_byte(input int unsigned b);
        logic [15:0] w;
        w = mem[18'(TB_BASE + 18'(b / 2))];
        return (b % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [23:0] model_pixel(input int unsigned idx);
        return {frame_byte(3*idx), frame_byte(3*idx + 1), frame_byte(3*idx + 2)};
    endfunction

    int unsigned exp_idx    = 0;
    logic        prev_stall = 1'b0;
    logic        prev_done  = 1'b0;
    logic        seen_last  = 1'b0;
    logic [23:0] prev_pix   = '0;

    always @(negedge CLOCK_50_I) begin
        if (!Resetn) begin
            exp_idx    = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            seen_last  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(pixel_valid), 32'd1);
                check("hold_pixel", 32'({pixel_R, pixel_G, pixel_B}), 32'(prev_pix));
            end
            if (pixel_valid && pixel_ready) begin
                if (exp_idx >= TB_PIXELS) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_pixel: got pixel index %0d expected at most %0d", exp_idx, TB_PIXELS - 1);
                end else begin
                    check("pixel", 32'({pixel_R, pixel_G, pixel_B}), 32'(model_pixel(exp_idx)));
                end
                exp_idx++;
            end
            prev_stall = pixel_valid && !pixel_ready;
            prev_pix   = {pixel_R, pixel_G, pixel_B};
            if (busy) begin
                check("addr_in_frame", 32'(address >= TB_BASE), 32'd1);
                check("write_en_n", 32'(write_en_n), 32'd1);
                if (address == TB_LAST) seen_last = 1'b1;
            end
            if (frame_done) begin
                check("done_after_all_pixels", exp_idx, TB_PIXELS);
                check("busy_during_done", 32'(busy), 32'd1);
            end
            if (prev_done) begin
                check("done_single_pulse", 32'(frame_done), 32'd0);
                check("busy_falls_with_done", 32'(busy), 32'd0);
            end
            prev_done = frame_done;
        end
    end

    int unsigned n;
    logic [17:0] addr_hold;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'($urandom);
        mem[TB_BASE]         = 16'h1122;
        mem[TB_BASE + 18'd1] = 16'h3344;
        mem[TB_BASE + 18'd2] = 16'h5566;

        Resetn = 1'b0; start = 1'b0; pixel_ready = 1'b0;
        repeat (3) @(posedge CLOCK_50_I);
        @(negedge CLOCK_50_I);
        check("rst_address",     32'(address),     32'(TB_BASE));
        check("rst_write_en_n",  32'(write_en_n),  32'd1);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_pixel_rgb",   32'({pixel_R, pixel_G, pixel_B}), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_frame_done",  32'(frame_done),  32'd0);
        @(posedge CLOCK_50_I); #1 Resetn = 1'b1;

        // Frame 1: consumer always ready; check the hand-packed first group.
        pixel_ready = 1'b1;
        @(posedge CLOCK_50_I); #1 start = 1'b1;
        @(posedge CLOCK_50_I); #1 start = 1'b0;
        n = 0;
        do begin @(negedge CLOCK_50_I); n++; end while (!pixel_valid && n < 50);
        check("f1_first_valid_seen", 32'(pixel_valid), 32'd1);
        check("f1_first_valid_not_early", 32'(n >= 7), 32'd1);
        check("f1_pixel0_literal", 32'({pixel_R, pixel_G, pixel_B}), 32'h112233);
        @(negedge CLOCK_50_I);
        check("f1_pixel1_back_to_back", 32'(pixel_valid), 32'd1);
        check("f1_pixel1_literal", 32'({pixel_R, pixel_G, pixel_B}), 32'h445566);

        // Reset while reads are in flight.
        repeat (40) @(posedge CLOCK_50_I);
        #1 Resetn = 1'b0;
        @(negedge CLOCK_50_I);
        check("midrst_address",     32'(address),     32'(TB_BASE));
        check("midrst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("midrst_busy",        32'(busy),        32'd0);
        check("midrst_frame_done",  32'(frame_done),  32'd0);
        pixel_ready = 1'b0;
        @(posedge CLOCK_50_I); #1 Resetn = 1'b1;

        // Frame 2: restart after reset, stall on the first pixel, then run to completion.
        @(posedge CLOCK_50_I); #1 start = 1'b1;
        @(posedge CLOCK_50_I); #1 start = 1'b0;
        n = 0;
        do begin @(negedge CLOCK_50_I); n++; end while (!pixel_valid && n < 50);
        check("f2_first_valid_seen", 32'(pixel_valid), 32'd1);
        check("f2_first_valid_not_early", 32'(n >= 7), 32'd1);
        check("f2_pixel0_from_base", 32'({pixel_R, pixel_G, pixel_B}), 32'h112233);
        addr_hold = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50_I);
            if (i == 11) addr_hold = address;
        end
        check("stall_reads_stop", 32'(address), 32'(addr_hold));
        check("stall_still_valid", 32'(pixel_valid), 32'd1);

        @(posedge CLOCK_50_I); #1 pixel_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50_I);
            check("burst_one_pixel_per_clk", 32'(pixel_valid), 32'd1);
        end

        n = 0;
        while (!frame_done && n < 20000) begin
            @(posedge CLOCK_50_I); #1;
            pixel_ready = ($urandom_range(0, 3) != 0);
            start       = (n == 200);
            @(negedge CLOCK_50_I);
            n++;
        end
        start = 1'b0;
        check("f2_frame_done_seen", 32'(frame_done), 32'd1);
        check("f2_last_word_read", 32'(seen_last), 32'd1);
        @(negedge CLOCK_50_I);
        check("f2_pixels_total", exp_idx, TB_PIXELS);
        check("post_busy",        32'(busy),        32'd0);
        check("post_address",     32'(address),     32'(TB_BASE));
        check("post_pixel_valid", 32'(pixel_valid), 32'd0);
        repeat (3) @(negedge CLOCK_50_I);
        check("idle_stays_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
